// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_ctrl
//  Purpose  : Sequences one instruction at a time through register read,
//             optional ALU execution and register write-back, with halt on
//             null/RETQ opcodes.
//  Options  : ALU_TIMEOUT_EN - bound the wait for alu_done to TIMEOUT_CYCLES
//             EXEC cycles; on expiry enter a sticky error/halt state.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    // instruction input
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [3:0]  in_dst,
    input  logic [3:0]  in_src,
    input  logic        in_src_imm,
    input  logic [63:0] in_imm,
    // register file
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [63:0] rf_rdata_a,
    input  logic [63:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    // ALU
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    input  logic        alu_done,
    input  logic [63:0] alu_lo,
    input  logic [63:0] alu_hi,
    // status
    output logic        busy,
    output logic        retired,
    output logic        halted,
    output logic        err
);

    localparam logic [2:0] c_op_null   = 3'd0;
    localparam logic [2:0] c_op_or     = 3'd2;
    localparam logic [2:0] c_op_and    = 3'd3;
    localparam logic [2:0] c_op_mov    = 3'd4;
    localparam logic [2:0] c_op_movabs = 3'd5;
    localparam logic [2:0] c_op_imul   = 3'd6;
    localparam logic [2:0] c_op_retq   = 3'd7;

    // S_ERR is only reachable when the ALU timeout is built in.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_HALT  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_op;
    logic [3:0]  r_dst;
    logic [3:0]  r_src;
    logic        r_src_imm;
    logic [63:0] r_imm;
    logic [63:0] r_vala;
    logic [63:0] r_valb;
    logic [63:0] r_res_lo;
    logic [63:0] r_res_hi;
    logic        r_first;

    logic        w_is_mov;
    logic        w_is_imul;
    logic [63:0] w_valb;
    logic [1:0]  w_alu_op;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign w_is_mov  = (r_op == c_op_mov) || (r_op == c_op_movabs);
    assign w_is_imul = (r_op == c_op_imul);
    assign w_valb    = r_src_imm ? r_imm : rf_rdata_b;

    // Map the instruction opcode onto the ALU operation encoding.
    always_comb begin
        w_alu_op = 2'd0;
        case (r_op)
            c_op_or:   w_alu_op = 2'd1;
            c_op_and:  w_alu_op = 2'd2;
            c_op_imul: w_alu_op = 2'd3;
            default:   w_alu_op = 2'd0;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        rf_raddr_a = 4'd0;
        rf_raddr_b = 4'd0;
        rf_we      = 1'b0;
        rf_waddr   = 4'd0;
        rf_wdata   = 64'd0;
        alu_start  = 1'b0;
        retired    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by reset so in_ready reads low while reset is held.
                in_ready = reset_n;
                if (in_valid) begin
                    if ((in_op == c_op_null) || (in_op == c_op_retq)) begin
                        w_next = S_HALT;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                rf_raddr_a = r_dst;
                rf_raddr_b = r_src_imm ? 4'd0 : r_src;
                w_next     = w_is_mov ? S_WB_LO : S_EXEC;
            end
            S_EXEC: begin
                alu_start = r_first;
                if (alu_done) begin
                    w_next = S_WB_LO;
                end
`ifdef ALU_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next = S_ERR;
                end
`endif
            end
            S_WB_LO: begin
                rf_we    = 1'b1;
                rf_waddr = w_is_imul ? 4'd0 : r_dst;
                rf_wdata = r_res_lo;
                if (w_is_imul) begin
                    w_next = S_WB_HI;
                end else begin
                    retired = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = 4'd2;
                rf_wdata = r_res_hi;
                retired  = 1'b1;
                w_next   = S_IDLE;
            end
            S_HALT:  w_next = S_HALT;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // ALU operands are presented only while executing and are held there.
    assign alu_a  = (r_state == S_EXEC) ? r_vala   : 64'd0;
    assign alu_b  = (r_state == S_EXEC) ? r_valb   : 64'd0;
    assign alu_op = (r_state == S_EXEC) ? w_alu_op : 2'd0;

    // ERR also counts as halted and therefore not busy.
    assign busy   = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
    assign halted = (r_state == S_HALT) || (r_state == S_ERR);
`ifdef ALU_TIMEOUT_EN
    assign err    = (r_state == S_ERR);
`else
    assign err    = 1'b0;
`endif

    // Instruction fields, operands and results captured along the pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= 3'd0;
            r_dst     <= 4'd0;
            r_src     <= 4'd0;
            r_src_imm <= 1'b0;
            r_imm     <= 64'd0;
            r_vala    <= 64'd0;
            r_valb    <= 64'd0;
            r_res_lo  <= 64'd0;
            r_res_hi  <= 64'd0;
            r_first   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= in_op;
                        r_dst     <= in_dst;
                        r_src     <= in_src;
                        r_src_imm <= in_src_imm;
                        r_imm     <= in_imm;
                    end
                end
                S_READ: begin
                    r_vala  <= rf_rdata_a;
                    r_valb  <= w_valb;
                    r_first <= 1'b1;
                    if (w_is_mov) begin
                        r_res_lo <= w_valb;
                    end
                end
                S_EXEC: begin
                    r_first <= 1'b0;
                    if (alu_done) begin
                        r_res_lo <= alu_lo;
                        r_res_hi <= alu_hi;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_TIMEOUT_EN
    // Counts EXEC cycles since alu_start; restarts with every instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, ALU-done wait limit; used only with ALU_TIMEOUT_EN.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have the instruction input ports:
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when high with in_valid.
- in_op  in  3  0 null, 1 ADD, 2 OR, 3 AND, 4 MOV, 5 MOVABS, 6 IMUL, 7 RETQ.
- in_dst  in  4  operand0 register number.
- in_src  in  4  operand1 register number.
- in_src_imm  in  1  operand1 is immediate.
- in_imm  in  64  immediate value.
REQ-004 SHALL have the register-file ports:
- rf_raddr_a, rf_raddr_b  out  4  read addresses; read is combinational.
- rf_rdata_a, rf_rdata_b  in  64  read data.
- rf_we  out  1  write strobe.
- rf_waddr  out  4  write address.
- rf_wdata  out  64  write data.
REQ-005 SHALL have the ALU ports:
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  2  0 add, 1 or, 2 and, 3 mul.
- alu_a, alu_b  out  64  operands.
- alu_done  in  1  result valid.
- alu_lo, alu_hi  in  64  result; hi is meaningful for mul only.
REQ-006 SHALL have the status ports:
- busy  out  1  state not IDLE/HALT.
- retired  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky halt.
- err  out  1  sticky ALU timeout.

Function
REQ-007 SHALL implement states IDLE, READ, EXEC, WB_LO, WB_HI, HALT (plus ERR under ALU_TIMEOUT_EN).
REQ-008 in_ready SHALL be 1 only in IDLE; on accept SHALL latch all in_* fields.
REQ-009 op 0 or 7 accepted -> HALT next cycle; no RF write; no retired pulse; halted=1 until reset.
REQ-010 READ: rf_raddr_a=dst, rf_raddr_b=src (0 if src_imm); SHALL capture vala=rf_rdata_a, valb=src_imm?imm:rf_rdata_b.
REQ-011 READ -> WB_LO for MOV/MOVABS with result=valb, no alu_start; otherwise -> EXEC.
REQ-012 EXEC: alu_start=1 in first EXEC cycle only; alu_a/alu_b/alu_op held stable throughout EXEC.
REQ-013 alu_done SHALL be honoured in any EXEC cycle including the start cycle; it captures alu_lo/alu_hi and moves to WB_LO; alu_done outside EXEC is ignored.
REQ-014 WB_LO: rf_we=1, rf_wdata=result lo, rf_waddr=dst (0 for IMUL); non-IMUL -> IDLE with retired=1 in that cycle.
REQ-015 IMUL WB_LO -> WB_HI: rf_we=1, rf_waddr=2, rf_wdata=alu_hi, retired=1 -> IDLE.
REQ-016 Latency SHALL be as follows:
- MOV: accept T, write T+2, in_ready T+3.
- ADD with done at start: write T+3.
- IMUL adds one cycle.
REQ-017 rf_we, alu_start, and retired SHALL be 0 in all states other than those stated above.

Reset
REQ-018 reset_n low SHALL immediately force IDLE, zero all outputs and latched fields, and clear halted/err, including mid-EXEC; the abandoned ALU result is never written.
REQ-019 First in_ready=1 SHALL be in the first cycle after reset_n deasserts.

Configuration
REQ-020 With ALU_TIMEOUT_EN defined, a counter SHALL count EXEC cycles; at TIMEOUT_CYCLES without alu_done -> ERR: err=1, halted=1, no write, sticky until reset.
REQ-021 Without ALU_TIMEOUT_EN, EXEC SHALL wait indefinitely, and err SHALL be tied 0.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- r1=5, ADD dst=1 imm=3, ALU done 2 cycles after start with lo=8 -> alu_a=5, alu_b=3, alu_op=0; single write r1=8; one retired pulse.
- r4=0xDEAD, MOV dst=3 src=4 -> write r3=0xDEAD at T+2; alu_start never asserts.
- r0=0xFFFFFFFFFFFFFFFF, IMUL imm=2, ALU returns hi=1, lo=0xFFFFFFFFFFFFFFFE -> r0=lo, next cycle r2=1; retired only on the second write.
- RETQ then in_valid held high -> halted=1; in_ready stays 0; no rf_we until reset.
- reset_n pulsed low during EXEC, then alu_done after release -> all outputs 0 during reset; no rf_we; next instruction accepted normally.
- ALU_TIMEOUT_EN defined, alu_done never asserted -> err=1 and halted=1 exactly 16 cycles after alu_start; no rf_we.
